// File: rtl/key_rotary_debounce.sv
// key_rotary_debounce
// Debounces two active-low push-keys and a 4-bit active-low rotary code.
// Each key has its own four-state FSM that produces a level, a press pulse
// and a release pulse. The rotary code is re-published once it has been
// stable for DEB_CYCLES samples.
//
// Optional feature: define KEY_REPEAT_EN to enable auto-repeat press pulses
// while a key is held. The default build (macro undefined) gives exactly one
// press pulse per press.
//
// Debounce timing: the first sample that differs from the current state
// counts as sample 1. The change is accepted on the DEB_CYCLES-th
// consecutive sample. With the two synchronizer stages in front, the pulse
// therefore follows a clean raw edge by exactly 2 + DEB_CYCLES clocks.

module key_rotary_debounce #(
  parameter logic [19:0] DEB_CYCLES    = 20'd500000,
  parameter logic [23:0] REPEAT_DELAY  = 24'd10000000,
  parameter logic [23:0] REPEAT_PERIOD = 24'd5000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_key_n,
  input  logic [3:0] i_rotary_n,
  output logic [1:0] o_key_level,
  output logic [1:0] o_key_press,
  output logic [1:0] o_key_release,
  output logic [3:0] o_rotary,
  output logic       o_rotary_chg
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

  // Counter ceiling, and the counter value at which the current sample is
  // the DEB_CYCLES-th stable one (the counter is cleared on sample 1).
  localparam logic [19:0] DEB_LAST_C = DEB_CYCLES - 20'd1;
  localparam logic [19:0] DEB_QUAL_C = DEB_CYCLES - 20'd2;

  // Saturating increment for the debounce counters.
  function automatic logic [19:0] deb_inc(input logic [19:0] cnt);
    if (cnt == DEB_LAST_C) begin
      return cnt;
    end else begin
      return cnt + 20'd1;
    end
  endfunction

  logic [1:0]  key_meta_r;
  logic [1:0]  key_sync_r;
  logic [3:0]  rot_meta_r;
  logic [3:0]  rot_sync_r;
  logic [1:0]  key_pressed_s;
  logic [3:0]  rot_code_s;

  key_state_e  key_state_r [2];
  logic [19:0] deb_cnt_r   [2];

  logic [3:0]  rot_cand_r;
  logic [19:0] rot_cnt_r;

`ifdef KEY_REPEAT_EN
  localparam logic [23:0] RPT_FIRST_C = REPEAT_DELAY - 24'd1;
  localparam logic [23:0] RPT_NEXT_C  = REPEAT_PERIOD - 24'd1;

  // rpt_phase_r is 0 while waiting for the first repeat and 1 afterwards.
  logic [23:0] rpt_cnt_r   [2];
  logic        rpt_phase_r [2];
`endif

  assign key_pressed_s = ~key_sync_r;
  assign rot_code_s    = ~rot_sync_r;

  // Two-flop synchronizers; reset to the all-released raw level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      key_meta_r <= 2'b11;
      key_sync_r <= 2'b11;
      rot_meta_r <= 4'hF;
      rot_sync_r <= 4'hF;
    end else begin
      key_meta_r <= i_key_n;
      key_sync_r <= key_meta_r;
      rot_meta_r <= i_rotary_n;
      rot_sync_r <= rot_meta_r;
    end
  end

  // Per-key debounce FSM with registered level/press/release outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < 2; k++) begin
        key_state_r[k] <= ST_IDLE;
        deb_cnt_r[k]   <= 20'd0;
`ifdef KEY_REPEAT_EN
        rpt_cnt_r[k]   <= 24'd0;
        rpt_phase_r[k] <= 1'b0;
`endif
      end
      o_key_level   <= 2'b00;
      o_key_press   <= 2'b00;
      o_key_release <= 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        o_key_press[k]   <= 1'b0;
        o_key_release[k] <= 1'b0;
        case (key_state_r[k])
          ST_IDLE: begin
            deb_cnt_r[k] <= 20'd0;
            if (key_pressed_s[k]) begin
              key_state_r[k] <= ST_PRESS_WAIT;
            end else begin
              key_state_r[k] <= ST_IDLE;
            end
          end
          ST_PRESS_WAIT: begin
            if (!key_pressed_s[k]) begin
              key_state_r[k] <= ST_IDLE;
              deb_cnt_r[k]   <= 20'd0;
            end else if (deb_cnt_r[k] == DEB_QUAL_C) begin
              key_state_r[k] <= ST_PRESSED;
              deb_cnt_r[k]   <= 20'd0;
              o_key_level[k] <= 1'b1;
              o_key_press[k] <= 1'b1;
`ifdef KEY_REPEAT_EN
              rpt_cnt_r[k]   <= 24'd0;
              rpt_phase_r[k] <= 1'b0;
`endif
            end else begin
              deb_cnt_r[k] <= deb_inc(deb_cnt_r[k]);
            end
          end
          ST_PRESSED: begin
            deb_cnt_r[k] <= 20'd0;
            if (!key_pressed_s[k]) begin
              key_state_r[k] <= ST_RELEASE_WAIT;
            end else begin
              key_state_r[k] <= ST_PRESSED;
`ifdef KEY_REPEAT_EN
              // First repeat after REPEAT_DELAY held cycles, then every
              // REPEAT_PERIOD cycles.
              if (rpt_cnt_r[k] == (rpt_phase_r[k] ? RPT_NEXT_C : RPT_FIRST_C)) begin
                rpt_cnt_r[k]   <= 24'd0;
                rpt_phase_r[k] <= 1'b1;
                o_key_press[k] <= 1'b1;
              end else begin
                rpt_cnt_r[k] <= rpt_cnt_r[k] + 24'd1;
              end
`endif
            end
          end
          ST_RELEASE_WAIT: begin
            if (key_pressed_s[k]) begin
              // Bounce while releasing: back to held, no pulses.
              key_state_r[k] <= ST_PRESSED;
              deb_cnt_r[k]   <= 20'd0;
`ifdef KEY_REPEAT_EN
              rpt_cnt_r[k]   <= 24'd0;
              rpt_phase_r[k] <= 1'b0;
`endif
            end else if (deb_cnt_r[k] == DEB_QUAL_C) begin
              key_state_r[k]   <= ST_IDLE;
              deb_cnt_r[k]     <= 20'd0;
              o_key_level[k]   <= 1'b0;
              o_key_release[k] <= 1'b1;
            end else begin
              deb_cnt_r[k] <= deb_inc(deb_cnt_r[k]);
            end
          end
          default: begin
            key_state_r[k] <= ST_IDLE;
            deb_cnt_r[k]   <= 20'd0;
            o_key_level[k] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Rotary candidate tracking and stable-code publication.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rot_cand_r   <= 4'h0;
      rot_cnt_r    <= 20'd0;
      o_rotary     <= 4'h0;
      o_rotary_chg <= 1'b0;
    end else begin
      o_rotary_chg <= 1'b0;
      if (rot_code_s != rot_cand_r) begin
        rot_cand_r <= rot_code_s;
        rot_cnt_r  <= 20'd0;
      end else if (rot_cnt_r == DEB_QUAL_C) begin
        rot_cnt_r <= deb_inc(rot_cnt_r);
        if (rot_cand_r != o_rotary) begin
          o_rotary     <= rot_cand_r;
          o_rotary_chg <= 1'b1;
        end else begin
          o_rotary <= o_rotary;
        end
      end else begin
        rot_cnt_r <= deb_inc(rot_cnt_r);
      end
    end
  end

endmodule

// File: tb/tb_key_rotary_debounce.sv
// Testbench for key_rotary_debounce: directed scenarios plus randomized
// stimulus, every cycle compared against a run-length reference model.
module tb_key_rotary_debounce;

  localparam int DEB  = 4;
  localparam int RDLY = 20;
  localparam int RPER = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key_n;
  logic [3:0] rot_n;
  logic [1:0] key_level;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic [3:0] rotary;
  logic       rotary_chg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_rotary_debounce #(
    .DEB_CYCLES   (20'd4),
    .REPEAT_DELAY (24'd20),
    .REPEAT_PERIOD(24'd8)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_key_n      (key_n),
    .i_rotary_n   (rot_n),
    .o_key_level  (key_level),
    .o_key_press  (key_press),
    .o_key_release(key_release),
    .o_rotary     (rotary),
    .o_rotary_chg (rotary_chg)
  );

  // Reference model state: raw-sample delay line, run lengths, hold times.
  logic [1:0] d1_key, d2_key;
  logic [3:0] d1_rot, d2_rot;
  logic [1:0] m_level, e_press, e_release;
  logic [3:0] e_rot, rot_cand;
  logic       e_chg;
  int         m_run [2];
  int         m_hold[2];
  int         rot_run;

  // Scenario bookkeeping, gathered from observed outputs.
  int cyc = 0;
  int mark;
  int first_press0, first_rel0;
  int n_press0, n_press1, n_rel0, n_chg;
  int press0_q[$];
  int exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock of the model: a change is accepted once DEB consecutive
  // synchronized samples disagree with the current debounced value.
  task automatic model_step();
    logic [1:0] kp;
    logic [3:0] rc;
    if (rst) begin
      d1_key = 2'b11; d2_key = 2'b11; d1_rot = 4'hF; d2_rot = 4'hF;
      m_level = 2'b00; e_press = 2'b00; e_release = 2'b00;
      e_rot = 4'h0; e_chg = 1'b0; rot_cand = 4'h0; rot_run = 1;
      for (int k = 0; k < 2; k++) begin
        m_run[k] = 0;
        m_hold[k] = 0;
      end
    end else begin
      kp = ~d2_key;
      rc = ~d2_rot;
      e_press = 2'b00; e_release = 2'b00; e_chg = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (kp[k] != m_level[k]) begin
          m_run[k]++;
          if (m_run[k] == DEB) begin
            m_level[k] = kp[k];
            m_run[k] = 0;
            m_hold[k] = 0;
            if (kp[k]) e_press[k] = 1'b1;
            else e_release[k] = 1'b1;
          end
        end else begin
          if (m_level[k]) begin
            if (m_run[k] != 0) begin
              m_hold[k] = 0;
            end else begin
              m_hold[k]++;
`ifdef KEY_REPEAT_EN
              if (m_hold[k] >= RDLY && ((m_hold[k] - RDLY) % RPER) == 0) e_press[k] = 1'b1;
`endif
            end
          end
          m_run[k] = 0;
        end
      end
      if (rc != rot_cand) begin
        rot_cand = rc;
        rot_run = 1;
      end else if (rot_run < DEB) begin
        rot_run++;
        if (rot_run == DEB && rc != e_rot) begin
          e_rot = rc;
          e_chg = 1'b1;
        end
      end
      d2_key = d1_key; d1_key = key_n;
      d2_rot = d1_rot; d1_rot = rot_n;
    end
  endtask

  task automatic start_scn();
    mark = cyc;
    first_press0 = -1; first_rel0 = -1;
    n_press0 = 0; n_press1 = 0; n_rel0 = 0; n_chg = 0;
    press0_q.delete();
  endtask

  task automatic run_cycle(input logic r, input logic [1:0] k, input logic [3:0] q);
    rst = r; key_n = k; rot_n = q;
    cyc++;
    @(posedge clk);
    model_step();
    #1;
    check_val("outputs", {19'd0, key_level, key_press, key_release, rotary, rotary_chg},
              {19'd0, m_level, e_press, e_release, e_rot, e_chg});
    if (key_press[0]) begin
      n_press0++;
      press0_q.push_back(cyc - mark);
      if (first_press0 < 0) first_press0 = cyc - mark;
    end
    if (key_press[1]) n_press1++;
    if (key_release[0]) begin
      n_rel0++;
      if (first_rel0 < 0) first_rel0 = cyc - mark;
    end
    if (rotary_chg) n_chg++;
  endtask

  initial begin
    logic [1:0] rk;
    logic [3:0] rq;
    logic       rr;
    int         len;
    int         obs;

    rst = 1'b1; key_n = 2'b11; rot_n = 4'hF;
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 2'b11, 4'hF);
    check_val("reset_outs", {19'd0, key_level, key_press, key_release, rotary, rotary_chg}, 32'd0);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 2'b11, 4'hF);

    // Clean press of key0.
    start_scn();
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 2'b10, 4'hF);
    check_val("press0_latency", first_press0, 6);
    check_val("press0_count", n_press0, 1);
    check_val("level0_set", key_level[0], 1'b1);

    // Release with a 2-cycle bounce, then stable release.
    for (int i = 0; i < 2; i++) run_cycle(1'b0, 2'b11, 4'hF);
    for (int i = 0; i < 2; i++) run_cycle(1'b0, 2'b10, 4'hF);
    start_scn();
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 2'b11, 4'hF);
    check_val("release0_latency", first_rel0, 6);
    check_val("release0_count", n_rel0, 1);
    check_val("level0_clear", key_level[0], 1'b0);

    // Short glitch on key1.
    start_scn();
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 2'b01, 4'hF);
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 2'b11, 4'hF);
    check_val("glitch1_press", n_press1, 0);
    check_val("glitch1_level", key_level[1], 1'b0);

    // Rotary change, then a short glitch that returns to the same code.
    start_scn();
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 2'b11, 4'hA);
    check_val("rot_chg_count", n_chg, 1);
    check_val("rot_value", rotary, 4'h5);
    start_scn();
    for (int i = 0; i < 2; i++) run_cycle(1'b0, 2'b11, 4'h2);
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 2'b11, 4'hA);
    check_val("rot_glitch_chg", n_chg, 0);
    check_val("rot_glitch_value", rotary, 4'h5);

    // Reset while key0 is held; it must re-qualify as a fresh press.
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 2'b10, 4'hA);
    check_val("held_level", key_level[0], 1'b1);
    run_cycle(1'b1, 2'b10, 4'hA);
    check_val("mid_reset_outs", {19'd0, key_level, key_press, key_release, rotary, rotary_chg}, 32'd0);
    start_scn();
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 2'b10, 4'hA);
    check_val("repress_latency", first_press0, 6);
    check_val("repress_no_release", n_rel0, 0);
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 2'b11, 4'hA);

    // Long hold of key0: press pulse schedule.
    start_scn();
    for (int i = 0; i < 50; i++) run_cycle(1'b0, 2'b10, 4'hA);
`ifdef KEY_REPEAT_EN
    exp_q = '{6, 26, 34, 42, 50};
`else
    exp_q = '{6};
`endif
    check_val("hold_press_count", n_press0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < press0_q.size()) ? press0_q[i] : -1;
      check_val("hold_press_time", obs, exp_q[i]);
    end
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 2'b11, 4'hA);

    // Randomized segments, every cycle checked against the model.
    rq = 4'hA;
    for (int s = 0; s < 400; s++) begin
      rk = 2'($urandom);
      if ($urandom_range(0, 9) < 4) rq = 4'($urandom);
      rr = ($urandom_range(0, 99) == 0);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 10);
      for (int c = 0; c < len; c++) run_cycle(rr && (c == 0), rk, rq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
